line_feed_controller: RTL and testbench

LINE_FEED_CONTROLLER -- requirements
Module: line_feed_controller

---
 rtl/line_feed_pkg.sv | 20 ++
 rtl/line_feed_controller_intr_pending.sv | 33 +++
 rtl/line_feed_controller.sv | 183 ++++++++++++++++++
 tb/tb_line_feed_controller.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/line_feed_pkg.sv
// Shared definitions for the line feed controller: FSM states and default geometry.
package line_feed_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRIME     = 3'd1,
    WAIT_INTR = 3'd2,
    LINE      = 3'd3,
    PAD_WAIT  = 3'd4,
    PAD       = 3'd5,
    DRAIN     = 3'd6,
    DONE      = 3'd7
  } state_t;

  localparam int DEF_LINE_WIDTH  = 512;
  localparam int DEF_IMG_LINES   = 512;
  localparam int DEF_PRIME_LINES = 4;
  localparam int DEF_PAD_LINES   = 2;

endpackage

// File: rtl/line_feed_controller_intr_pending.sv
// Rising-edge detector on the edge-detector interrupt with a sticky pending flag.
module intr_pending (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  input  logic intr,
  output logic pending,
  output logic overrun_hit
);

  logic intr_q;
  logic edge_hit;

  assign edge_hit    = enable && intr && !intr_q;
  // A second edge before the first was consumed means a line buffer slot was lost.
  assign overrun_hit = edge_hit && pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      intr_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      intr_q <= intr;
      if (edge_hit) begin
        pending <= 1'b1;
      end else if (clear) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/line_feed_controller.sv
// Feeds image lines (then zero pad lines) to an edge detector, paced by its
// line-buffer-free interrupt, and waits for all output pixels before finishing.
module line_feed_controller
  import line_feed_pkg::*;
#(
  parameter int LINE_WIDTH  = DEF_LINE_WIDTH,
  parameter int IMG_LINES   = DEF_IMG_LINES,
  parameter int PRIME_LINES = DEF_PRIME_LINES,
  parameter int PAD_LINES   = DEF_PAD_LINES
) (
  input  logic                                       axi_clk,
  input  logic                                       axi_reset_n,
  input  logic                                       i_start,
  input  logic [7:0]                                 s_data,
  input  logic                                       s_valid,
  output logic                                       s_ready,
  output logic [7:0]                                 o_data,
  output logic                                       o_data_valid,
  input  logic                                       i_det_ready,
  input  logic                                       i_intr,
  input  logic                                       i_out_valid,
  output logic                                       o_busy,
  output logic                                       o_done,
  output logic                                       o_overrun,
  output logic [$clog2(IMG_LINES+PAD_LINES)-1:0]     o_line,
  output state_t                                     dbg_state
);

  localparam int PIX_W     = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
  localparam int LINE_W    = $clog2(IMG_LINES + PAD_LINES);
  localparam int PADC_W    = (PAD_LINES > 1) ? $clog2(PAD_LINES + 1) : 1;
  localparam int OUT_TOTAL = IMG_LINES * LINE_WIDTH;
  localparam int OUT_W     = $clog2(OUT_TOTAL + 1);

  localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(LINE_WIDTH - 1);
  localparam logic [LINE_W-1:0] PRIME_LAST = LINE_W'(PRIME_LINES - 1);
  localparam logic [LINE_W-1:0] IMG_LAST   = LINE_W'(IMG_LINES - 1);
  localparam logic [PADC_W-1:0] PAD_LAST   = PADC_W'(PAD_LINES - 1);
  localparam logic [OUT_W-1:0]  OUT_MAX    = OUT_W'(OUT_TOTAL);
  localparam bit                SHORT_IMG  = (IMG_LINES <= PRIME_LINES);

  state_t              state, state_n;
  logic [PIX_W-1:0]    pix_cnt;
  logic [LINE_W-1:0]   line_cnt;
  logic [PADC_W-1:0]   pad_cnt;
  logic [OUT_W-1:0]    out_cnt;
  logic                overrun;
  logic                pending;
  logic                overrun_hit;
  logic                pend_clr;
  logic                start_ok;
  logic                xfer;
  logic                line_end;

  // Valid/ready: a beat moves only on a cycle where o_data_valid and
  // i_det_ready are both high; in PRIME/LINE the source handshake is the
  // same beat since s_ready mirrors i_det_ready and o_data_valid mirrors s_valid.
  assign xfer     = o_data_valid && i_det_ready;
  assign line_end = xfer && (pix_cnt == PIX_LAST);

  assign o_busy    = (state != IDLE) && (state != DONE);
  assign o_done    = (state == DONE);
  assign o_overrun = overrun;
  assign o_line    = line_cnt;
  assign dbg_state = state;

  intr_pending u_intr_pending (
    .clk         (axi_clk),
    .rst_n       (axi_reset_n),
    .enable      (state != IDLE),
    .clear       (pend_clr),
    .intr        (i_intr),
    .pending     (pending),
    .overrun_hit (overrun_hit)
  );

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n      = state;
    s_ready      = 1'b0;
    o_data       = 8'd0;
    o_data_valid = 1'b0;
    pend_clr     = 1'b0;
    start_ok     = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          start_ok = 1'b1;
          pend_clr = 1'b1;
          state_n  = PRIME;
        end
      end
      PRIME: begin
        o_data       = s_data;
        o_data_valid = s_valid;
        s_ready      = i_det_ready;
        if (line_end && (line_cnt == PRIME_LAST)) begin
          state_n = SHORT_IMG ? PAD_WAIT : WAIT_INTR;
        end
      end
      WAIT_INTR: begin
        if (pending) begin
          pend_clr = 1'b1;
          state_n  = LINE;
        end
      end
      LINE: begin
        o_data       = s_data;
        o_data_valid = s_valid;
        s_ready      = i_det_ready;
        if (line_end) begin
          state_n = (line_cnt < IMG_LAST) ? WAIT_INTR : PAD_WAIT;
        end
      end
      PAD_WAIT: begin
        if (pending) begin
          pend_clr = 1'b1;
          state_n  = PAD;
        end
      end
      PAD: begin
        o_data_valid = 1'b1;
        if (line_end) begin
          state_n = (pad_cnt < PAD_LAST) ? PAD_WAIT : DRAIN;
        end
      end
      DRAIN: begin
        if (out_cnt == OUT_MAX) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      pad_cnt  <= '0;
      out_cnt  <= '0;
      overrun  <= 1'b0;
    end else if (start_ok) begin
      pix_cnt  <= '0;
      line_cnt <= '0;
      pad_cnt  <= '0;
      out_cnt  <= '0;
      overrun  <= 1'b0;
    end else begin
      if (xfer) begin
        if (pix_cnt == PIX_LAST) begin
          pix_cnt  <= '0;
          line_cnt <= line_cnt + 1'b1;
          if (state == PAD) begin
            pad_cnt <= pad_cnt + 1'b1;
          end
        end else begin
          pix_cnt <= pix_cnt + 1'b1;
        end
      end
      // Saturate so stray strobes after the last output pixel cannot wrap.
      if (i_out_valid && o_busy && (out_cnt != OUT_MAX)) begin
        out_cnt <= out_cnt + 1'b1;
      end
      if (overrun_hit) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_line_feed_controller.sv
// Directed bench for line_feed_controller with an 8x8 image, 4 prime and 2 pad lines.
module tb_line_feed_controller;
  import line_feed_pkg::*;

  localparam int LW = 8;
  localparam int IL = 8;
  localparam int PL = 4;
  localparam int PD = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       det_ready;
  logic       intr;
  logic       out_valid;
  logic       o_busy;
  logic       o_done;
  logic       o_overrun;
  logic [3:0] o_line;
  state_t     dbg_state;

  line_feed_controller #(
    .LINE_WIDTH  (LW),
    .IMG_LINES   (IL),
    .PRIME_LINES (PL),
    .PAD_LINES   (PD)
  ) dut (
    .axi_clk      (clk),
    .axi_reset_n  (rst_n),
    .i_start      (start),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_det_ready  (det_ready),
    .i_intr       (intr),
    .i_out_valid  (out_valid),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_overrun    (o_overrun),
    .o_line       (o_line),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total;
  int         bad;
  logic [7:0] exp_q[$];
  logic [7:0] src;
  int         xfers;
  int         ov_left;
  int         ov_after;
  logic       tog;
  logic       tog_ph;

  typedef struct {
    logic       start;
    logic       det;
    logic       intr;
    state_t     st;
    logic       dv;
    logic       sr;
    logic       busy;
    logic [7:0] data;
    int         line;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock cycle: drive, sample at posedge+2, score transfers, advance.
  task automatic cycle();
    logic hs;
    logic [7:0] exp_b;
    if (tog) begin
      det_ready = tog_ph;
      tog_ph    = ~tog_ph;
    end
    out_valid = (ov_left > 0) && (xfers >= ov_after);
    s_data    = src;
    #1;
    if (o_data_valid && det_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        check("sb_extra_beat", 1, 0);
      end else begin
        exp_b = exp_q.pop_front();
        check("sb_data", int'(o_data), int'(exp_b));
      end
    end
    hs = s_valid && s_ready;
    @(posedge clk);
    #1;
    if (hs) src = src + 8'd1;
    if (out_valid) ov_left--;
  endtask

  task automatic wait_state(input state_t target, input int max_cyc, output int n);
    n = 0;
    while (dbg_state != target && n < max_cyc) begin
      cycle();
      n++;
    end
    if (dbg_state != target) check($sformatf("timeout_%s", target.name()), int'(dbg_state), int'(target));
  endtask

  task automatic pulse_intr();
    intr = 1'b1;
    cycle();
    intr = 1'b0;
  endtask

  task automatic do_start();
    src   = 8'd0;
    xfers = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic push_frame(input int n_img);
    for (int k = 0; k < n_img; k++) exp_q.push_back(8'(k));
    for (int k = 0; k < LW * PD; k++) exp_q.push_back(8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic hs;
    total = 0; bad = 0;
    src = 8'd0; xfers = 0; ov_left = 0; ov_after = 0; tog = 1'b0; tog_ph = 1'b0;
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b1; s_data = 8'd0;
    det_ready = 1'b1; intr = 1'b0; out_valid = 1'b0;

    // start, det, intr, state, dv, sr, busy, data, line
    vecs[0]  = '{1'b1, 1'b1, 1'b0, IDLE,  1'b0, 1'b0, 1'b0, 8'd0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, PRIME, 1'b1, 1'b1, 1'b1, 8'd0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, PRIME, 1'b1, 1'b0, 1'b1, 8'd1, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, PRIME, 1'b1, 1'b0, 1'b1, 8'd1, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, PRIME, 1'b1, 1'b1, 1'b1, 8'd1, 0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, PRIME, 1'b1, 1'b1, 1'b1, 8'd2, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, PRIME, 1'b1, 1'b1, 1'b1, 8'd3, 0};
    vecs[7]  = '{1'b0, 1'b1, 1'b1, PRIME, 1'b1, 1'b1, 1'b1, 8'd4, 0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, PRIME, 1'b1, 1'b1, 1'b1, 8'd5, 0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, PRIME, 1'b1, 1'b1, 1'b1, 8'd6, 0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, PRIME, 1'b1, 1'b1, 1'b1, 8'd7, 0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, PRIME, 1'b1, 1'b1, 1'b1, 8'd8, 1};

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    check("rst_overrun", int'(o_overrun), 0);
    check("rst_dv", int'(o_data_valid), 0);
    check("rst_s_ready", int'(s_ready), 0);
    check("rst_data", int'(o_data), 0);
    check("rst_line", int'(o_line), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table-driven opening of a frame
    for (int i = 0; i < 12; i++) begin
      start = vecs[i].start; det_ready = vecs[i].det; intr = vecs[i].intr; s_data = src;
      #1;
      check($sformatf("vec%0d_state", i), int'(dbg_state), int'(vecs[i].st));
      check($sformatf("vec%0d_dv", i), int'(o_data_valid), int'(vecs[i].dv));
      check($sformatf("vec%0d_sr", i), int'(s_ready), int'(vecs[i].sr));
      check($sformatf("vec%0d_busy", i), int'(o_busy), int'(vecs[i].busy));
      check($sformatf("vec%0d_data", i), int'(o_data), int'(vecs[i].data));
      check($sformatf("vec%0d_line", i), int'(o_line), vecs[i].line);
      hs = s_valid && s_ready;
      @(posedge clk);
      #1;
      if (hs) src = src + 8'd1;
    end
    start = 1'b0; intr = 1'b0; det_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    check("prime_rst_dv", int'(o_data_valid), 0);
    check("prime_rst_state", int'(dbg_state), int'(IDLE));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // full frame, continuous ready, exactly 64 output strobes
    push_frame(IL * LW);
    ov_after = 16; ov_left = 64;
    do_start();
    check("b_state_prime", int'(dbg_state), int'(PRIME));
    wait_state(WAIT_INTR, 200, n);
    check("b_prime_cycles", n, PL * LW);
    check("b_prime_xfers", xfers, PL * LW);
    check("b_wait_dv", int'(o_data_valid), 0);
    check("b_wait_line", int'(o_line), PL);
    for (int l = 0; l < IL - PL; l++) begin
      repeat (3) cycle();
      check("b_wait_hold", int'(dbg_state), int'(WAIT_INTR));
      pulse_intr();
      wait_state(LINE, 10, n);
      wait_state((l < IL - PL - 1) ? WAIT_INTR : PAD_WAIT, 20, n);
      check("b_line_len", n, LW);
    end
    check("b_img_xfers", xfers, IL * LW);
    check("b_img_line", int'(o_line), IL);
    for (int p = 0; p < PD; p++) begin
      pulse_intr();
      wait_state(PAD, 10, n);
      for (int k = 0; k < LW; k++) begin
        check("b_pad_s_ready", int'(s_ready), 0);
        cycle();
      end
      check("b_pad_exit", int'(dbg_state), int'((p == 0) ? PAD_WAIT : DRAIN));
    end
    wait_state(DONE, 100, n);
    check("b_done", int'(o_done), 1);
    check("b_done_busy", int'(o_busy), 0);
    cycle();
    check("b_idle", int'(dbg_state), int'(IDLE));
    check("b_done_low", int'(o_done), 0);
    check("b_idle_busy", int'(o_busy), 0);
    check("b_overrun", int'(o_overrun), 0);
    check("b_total_xfers", xfers, (IL + PD) * LW);
    check("b_sb_empty", exp_q.size(), 0);

    // toggling ready, edges during LINE, overrun, excess output strobes
    push_frame(IL * LW);
    ov_after = 16; ov_left = 80;
    do_start();
    tog_ph = 1'b0; tog = 1'b1;
    wait_state(WAIT_INTR, 200, n);
    check("c_prime_cycles", n, 2 * PL * LW);
    check("c_prime_xfers", xfers, PL * LW);
    tog = 1'b0; det_ready = 1'b1;
    pulse_intr();
    wait_state(LINE, 10, n);
    cycle();
    cycle();
    pulse_intr();
    wait_state(WAIT_INTR, 20, n);
    check("c_line_rest", n, LW - 3);
    cycle();
    check("c_latched_exit", int'(dbg_state), int'(LINE));
    check("c_no_overrun", int'(o_overrun), 0);
    pulse_intr();
    cycle();
    pulse_intr();
    check("c_overrun", int'(o_overrun), 1);
    wait_state(WAIT_INTR, 20, n);
    cycle();
    check("c_held_pending", int'(dbg_state), int'(LINE));
    wait_state(WAIT_INTR, 20, n);
    pulse_intr();
    wait_state(LINE, 10, n);
    wait_state(PAD_WAIT, 20, n);
    for (int p = 0; p < PD; p++) begin
      pulse_intr();
      wait_state(PAD, 10, n);
      wait_state((p == 0) ? PAD_WAIT : DRAIN, 20, n);
    end
    wait_state(DONE, 300, n);
    check("c_done", int'(o_done), 1);
    check("c_overrun_sticky", int'(o_overrun), 1);
    check("c_sb_empty", exp_q.size(), 0);
    cycle();

    // reset in the middle of LINE, then restart from line 0
    ov_left = 0;
    for (int k = 0; k < PL * LW + 4; k++) exp_q.push_back(8'(k));
    do_start();
    check("d_overrun_clear", int'(o_overrun), 0);
    wait_state(WAIT_INTR, 200, n);
    pulse_intr();
    wait_state(LINE, 10, n);
    repeat (4) cycle();
    check("d_line_before", int'(o_line), PL);
    rst_n = 1'b0;
    #1;
    check("d_rst_dv", int'(o_data_valid), 0);
    check("d_rst_busy", int'(o_busy), 0);
    check("d_rst_s_ready", int'(s_ready), 0);
    check("d_rst_line", int'(o_line), 0);
    check("d_rst_data", int'(o_data), 0);
    check("d_sb_empty", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle();
    check("d_stay_idle", int'(dbg_state), int'(IDLE));
    check("d_idle_busy", int'(o_busy), 0);
    for (int k = 0; k < LW; k++) exp_q.push_back(8'(k));
    do_start();
    check("d_restart_line", int'(o_line), 0);
    check("d_restart_state", int'(dbg_state), int'(PRIME));
    repeat (LW) cycle();
    check("d_restart_line1", int'(o_line), 1);
    check("d_restart_sb", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
